// File: rtl/histeq_pkg.sv
// Shared types and constants for the histogram-equalization frame sequencer.
// Contents: the seq_state_t state enum, default widths, and raw state codes
// for the status register.
package histeq_pkg;

    localparam int unsigned HE_PIX_W   = 8;
    localparam int unsigned HE_BINS    = 1 << HE_PIX_W;
    localparam int unsigned HE_DIM_W   = 12;
    localparam int unsigned HE_CNT_W   = 2 * HE_DIM_W;
    localparam int unsigned HE_STATE_W = 3;

    typedef enum logic [HE_STATE_W-1:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_ACCUM     = 3'd2,
        S_CDF       = 3'd3,
        S_CDF_FLUSH = 3'd4,
        S_REMAP     = 3'd5,
        S_DONE      = 3'd6
    } seq_state_t;

    // Raw codes as they appear in the status register
    localparam logic [HE_STATE_W-1:0] STATE_IDLE      = 3'd0;
    localparam logic [HE_STATE_W-1:0] STATE_CLEAR     = 3'd1;
    localparam logic [HE_STATE_W-1:0] STATE_ACCUM     = 3'd2;
    localparam logic [HE_STATE_W-1:0] STATE_CDF       = 3'd3;
    localparam logic [HE_STATE_W-1:0] STATE_CDF_FLUSH = 3'd4;
    localparam logic [HE_STATE_W-1:0] STATE_REMAP     = 3'd5;
    localparam logic [HE_STATE_W-1:0] STATE_DONE      = 3'd6;

    // True for the passes that consume the pixel stream
    function automatic logic is_pix_pass(input seq_state_t s);
        return (s == S_ACCUM) || (s == S_REMAP);
    endfunction

endpackage

// File: rtl/histeq_pass_cnt.sv
// Loadable terminal counter used for bin sweeps and per-pass pixel counts.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clr_i       force count to 0 (wins over inc_i)
//   ld_i        capture term_i as the terminal value
//   term_i      terminal (last) count value
//   inc_i       advance; wraps to 0 when incrementing from the terminal value
//   cnt_o       current count
//   last_o      count equals the terminal value
module histeq_pass_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] term_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] term_q, term_d;

    // Next count and terminal value
    always_comb begin
        cnt_d  = cnt_q;
        term_d = term_q;
        if (ld_i) begin
            term_d = term_i;
        end
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = last_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            term_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == term_q);

endmodule

// File: rtl/histeq_seq_ctrl.sv
// Frame-level sequencer for the histogram-equalization datapath.
// Pass order: histogram clear -> accumulate -> CDF/LUT build -> pixel remap.
// Ports:
//   ACLK, ARESETN           clock, async active-low reset
//   cfg_start / cfg_abort   one-cycle control pulses from the register block
//   cfg_width / cfg_height  frame size, sampled on an accepted start
//   s_pix_valid/s_pix_ready pixel-stream handshake (ready gated per pass)
//   pix_last                final accepted pixel of a pass
//   hist_clr_we, hist_inc_en, cdf_rd_en, cdf_wr_en, bin_addr, remap_en
//                           datapath strobes and bin index
//   busy, done, cfg_err, state_o  status
// Optional feature macro: HISTEQ_SEQ_CTRL_PERF_EN adds perf_busy_cyc and
// perf_stall_cyc saturating 32-bit cycle counters.
module histeq_seq_ctrl
    import histeq_pkg::*;
#(
    parameter int unsigned PIX_W = HE_PIX_W,
    parameter int unsigned DIM_W = HE_DIM_W,
    parameter int unsigned CNT_W = 2 * DIM_W
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic             s_pix_valid,
    output logic             s_pix_ready,
    output logic             pix_last,
    output logic             hist_clr_we,
    output logic             hist_inc_en,
    output logic             cdf_rd_en,
    output logic             cdf_wr_en,
    output logic [PIX_W-1:0] bin_addr,
    output logic             remap_en,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [2:0]       state_o
`ifdef HISTEQ_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_busy_cyc,
    output logic [31:0]      perf_stall_cyc
`endif
);

    localparam int unsigned PERF_W = 32;

    seq_state_t state_q, state_d;

    logic ready_q, busy_q, clr_we_q, rd_en_q, wr_en_q, done_q, err_q;
    logic err_d;
    logic start_ok;

    logic             bin_clr, bin_ld, bin_inc, bin_last;
    logic [PIX_W-1:0] bin_cnt;
    logic             pix_clr, pix_ld, pix_last_flag;
    logic [CNT_W-1:0] pix_term;
    // Only the terminal flag of the pixel count is consumed
    logic [CNT_W-1:0] pix_cnt_unused;

    logic hs;
    logic dims_ok;

    assign hs       = s_pix_valid & ready_q;
    assign dims_ok  = (cfg_width != '0) && (cfg_height != '0);
    // Both dimensions nonzero on acceptance, so total-1 cannot underflow
    assign pix_term = (CNT_W'(cfg_width) * CNT_W'(cfg_height)) - CNT_W'(1);
    assign bin_inc  = (state_q == S_CLEAR) || (state_q == S_CDF);

    // Next-state and counter control
    always_comb begin
        state_d  = state_q;
        err_d    = 1'b0;
        start_ok = 1'b0;
        bin_clr  = 1'b0;
        bin_ld   = 1'b0;
        pix_clr  = 1'b0;
        pix_ld   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Abort in the same cycle suppresses both acceptance and error
                if (cfg_start && !cfg_abort) begin
                    if (dims_ok) begin
                        state_d  = S_CLEAR;
                        start_ok = 1'b1;
                        bin_clr  = 1'b1;
                        bin_ld   = 1'b1;
                        pix_clr  = 1'b1;
                        pix_ld   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                if (bin_last) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (hs && pix_last_flag) state_d = S_CDF;
            end
            S_CDF: begin
                if (bin_last) state_d = S_CDF_FLUSH;
            end
            S_CDF_FLUSH: begin
                state_d = S_REMAP;
            end
            S_REMAP: begin
                if (hs && pix_last_flag) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cfg_abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            bin_clr = 1'b1;
            pix_clr = 1'b1;
        end
    end

    // State and registered status/strobe outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            clr_we_q <= 1'b0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= is_pix_pass(state_d);
            busy_q   <= (state_d != S_IDLE);
            clr_we_q <= (state_d == S_CLEAR);
            rd_en_q  <= (state_d == S_CDF);
            // Histogram RAM has one cycle of read latency ahead of the LUT write
            wr_en_q  <= rd_en_q;
            done_q   <= (state_d == S_DONE);
            err_q    <= err_d;
        end
    end

    histeq_pass_cnt #(.W(PIX_W)) u_bin_cnt (
        .clk    (ACLK),
        .rst_n  (ARESETN),
        .clr_i  (bin_clr),
        .ld_i   (bin_ld),
        .term_i ({PIX_W{1'b1}}),
        .inc_i  (bin_inc),
        .cnt_o  (bin_cnt),
        .last_o (bin_last)
    );

    histeq_pass_cnt #(.W(CNT_W)) u_pix_cnt (
        .clk    (ACLK),
        .rst_n  (ARESETN),
        .clr_i  (pix_clr),
        .ld_i   (pix_ld),
        .term_i (pix_term),
        .inc_i  (hs),
        .cnt_o  (pix_cnt_unused),
        .last_o (pix_last_flag)
    );

    assign s_pix_ready = ready_q;
    assign hist_inc_en = hs & (state_q == S_ACCUM);
    assign remap_en    = hs & (state_q == S_REMAP);
    assign pix_last    = hs & pix_last_flag;
    assign hist_clr_we = clr_we_q;
    assign cdf_rd_en   = rd_en_q;
    assign cdf_wr_en   = wr_en_q;
    assign bin_addr    = bin_cnt;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = err_q;
    assign state_o     = state_q;

`ifdef HISTEQ_SEQ_CTRL_PERF_EN
    logic [PERF_W-1:0] busy_cyc_q, busy_cyc_d;
    logic [PERF_W-1:0] stall_cyc_q, stall_cyc_d;

    // Saturating counters, cleared on an accepted start
    always_comb begin
        busy_cyc_d  = busy_cyc_q;
        stall_cyc_d = stall_cyc_q;
        if (start_ok) begin
            busy_cyc_d  = '0;
            stall_cyc_d = '0;
        end else begin
            if (busy_q && (busy_cyc_q != '1)) begin
                busy_cyc_d = busy_cyc_q + PERF_W'(1);
            end
            if (ready_q && !s_pix_valid && (stall_cyc_q != '1)) begin
                stall_cyc_d = stall_cyc_q + PERF_W'(1);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            busy_cyc_q  <= '0;
            stall_cyc_q <= '0;
        end else begin
            busy_cyc_q  <= busy_cyc_d;
            stall_cyc_q <= stall_cyc_d;
        end
    end

    assign perf_busy_cyc  = busy_cyc_q;
    assign perf_stall_cyc = stall_cyc_q;
`else
    logic start_ok_unused;
    assign start_ok_unused = start_ok;
`endif

endmodule

// File: tb/tb_histeq_seq_ctrl.sv
// Scoreboard bench for histeq_seq_ctrl: stimulus pushes expected strobe
// tokens, a negedge monitor pops and compares whenever any strobe is active.
module tb_histeq_seq_ctrl;

    logic        ACLK;
    logic        ARESETN;
    logic        cfg_start, cfg_abort;
    logic [11:0] cfg_width, cfg_height;
    logic        s_pix_valid, s_pix_ready, pix_last;
    logic        hist_clr_we, hist_inc_en, cdf_rd_en, cdf_wr_en, remap_en;
    logic [7:0]  bin_addr;
    logic        busy, done, cfg_err;
    logic [2:0]  state_o;
`ifdef HISTEQ_SEQ_CTRL_PERF_EN
    logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif

    histeq_seq_ctrl dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .cfg_start   (cfg_start),
        .cfg_abort   (cfg_abort),
        .cfg_width   (cfg_width),
        .cfg_height  (cfg_height),
        .s_pix_valid (s_pix_valid),
        .s_pix_ready (s_pix_ready),
        .pix_last    (pix_last),
        .hist_clr_we (hist_clr_we),
        .hist_inc_en (hist_inc_en),
        .cdf_rd_en   (cdf_rd_en),
        .cdf_wr_en   (cdf_wr_en),
        .bin_addr    (bin_addr),
        .remap_en    (remap_en),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err),
        .state_o     (state_o)
`ifdef HISTEQ_SEQ_CTRL_PERF_EN
        ,
        .perf_busy_cyc  (perf_busy_cyc),
        .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    // Token flag bits: {clr, inc, rd, wr, remap, last, done, err}
    localparam logic [7:0] F_CLR  = 8'h80;
    localparam logic [7:0] F_INC  = 8'h40;
    localparam logic [7:0] F_RD   = 8'h20;
    localparam logic [7:0] F_WR   = 8'h10;
    localparam logic [7:0] F_REM  = 8'h08;
    localparam logic [7:0] F_LAST = 8'h04;
    localparam logic [7:0] F_DONE = 8'h02;
    localparam logic [7:0] F_ERR  = 8'h01;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] obs, exp_tok;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Monitor: compare every strobe-active cycle with the scoreboard head
    always @(negedge ACLK) begin
        if (ARESETN) begin
            obs = {hist_clr_we, hist_inc_en, cdf_rd_en, cdf_wr_en,
                   remap_en, pix_last, done, cfg_err, bin_addr};
            if (obs[15:8] != 8'h00) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe got=%h want=none t=%0t", obs, $time);
                end else begin
                    exp_tok = exp_q.pop_front();
                    if (obs !== exp_tok) begin
                        n_fail++;
                        $display("FAIL strobe_seq got=%h want=%h t=%0t", obs, exp_tok, $time);
                    end
                end
            end
            if (hist_inc_en || remap_en) begin
                n_tests++;
                if (!(s_pix_valid && s_pix_ready)) begin
                    n_fail++;
                    $display("FAIL strobe_without_handshake got=valid%0d/ready%0d want=1/1 t=%0t",
                             s_pix_valid, s_pix_ready, $time);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    task automatic push_clear(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({F_CLR, 8'(k)});
    endtask

    task automatic push_pix(input logic [7:0] f, input int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back({f | ((k == n - 1) ? F_LAST : 8'h00), 8'h00});
    endtask

    task automatic push_cdf();
        exp_q.push_back({F_RD, 8'h00});
        for (int k = 1; k < 256; k++) exp_q.push_back({F_RD | F_WR, 8'(k)});
        exp_q.push_back({F_WR, 8'h00});
    endtask

    task automatic push_frame(input int npix);
        push_clear(256);
        push_pix(F_INC, npix);
        push_cdf();
        push_pix(F_REM, npix);
        exp_q.push_back({F_DONE, 8'h00});
    endtask

    // Pulse start; returns just after the edge that samples it
    task automatic do_start(input logic [11:0] w, input logic [11:0] h);
        @(posedge ACLK); #1;
        cfg_width  = w;
        cfg_height = h;
        cfg_start  = 1'b1;
        @(posedge ACLK); #1;
        cfg_start  = 1'b0;
    endtask

    // Wait (bounded) for the scoreboard to empty, then idle a few cycles
    task automatic drain(input string name, input int budget, input bit tog);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge ACLK); #1;
            if (tog) s_pix_valid = ~s_pix_valid;
            c++;
        end
        chk({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (5) @(posedge ACLK);
        #1;
    endtask

    task automatic wait_state(input string name, input logic [2:0] st, input int budget);
        int c;
        c = 0;
        while (state_o != st && c < budget) begin
            @(posedge ACLK); #1;
            c++;
        end
        chk({name, "_reach_state"}, 32'(state_o), 32'(st));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETN     = 1'b0;
        cfg_start   = 1'b0;
        cfg_abort   = 1'b0;
        cfg_width   = '0;
        cfg_height  = '0;
        s_pix_valid = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_busy",   32'(busy), 0);
        chk("rst_state",  32'(state_o), 0);
        chk("rst_ready",  32'(s_pix_ready), 0);
        chk("rst_clr_we", 32'(hist_clr_we), 0);
        chk("rst_bin",    32'(bin_addr), 0);
        chk("rst_done",   32'(done), 0);
        ARESETN = 1'b1;

        // Full 4x2 frame, valid held high
        s_pix_valid = 1'b1;
        push_frame(8);
        do_start(12'd4, 12'd2);
        chk("f1_busy_after_start", 32'(busy), 1);
        chk("f1_state_clear", 32'(state_o), 1);
        drain("f1", 2000, 1'b0);
        chk("f1_state_idle", 32'(state_o), 0);
        chk("f1_busy_idle", 32'(busy), 0);
`ifdef HISTEQ_SEQ_CTRL_PERF_EN
        chk("f1_perf_busy", perf_busy_cyc, 32'd530);
        chk("f1_perf_stall", perf_stall_cyc, 32'd0);
`endif

        // Zero width rejected
        exp_q.push_back({F_ERR, 8'h00});
        do_start(12'd0, 12'd5);
        chk("err_pulse", 32'(cfg_err), 1);
        chk("err_busy", 32'(busy), 0);
        @(posedge ACLK); #1;
        chk("err_pulse_end", 32'(cfg_err), 0);
        chk("err_busy2", 32'(busy), 0);
        drain("err", 10, 1'b0);

        // Start and abort together in IDLE: abort wins
        @(posedge ACLK); #1;
        cfg_width = 12'd3; cfg_height = 12'd3;
        cfg_start = 1'b1; cfg_abort = 1'b1;
        @(posedge ACLK); #1;
        cfg_start = 1'b0; cfg_abort = 1'b0;
        chk("startabort_busy", 32'(busy), 0);
        chk("startabort_err", 32'(cfg_err), 0);
        drain("startabort", 10, 1'b0);

        // 3x1 frame with valid toggling every cycle
        s_pix_valid = 1'b1;
        push_frame(3);
        do_start(12'd3, 12'd1);
        drain("tog", 3000, 1'b1);
        chk("tog_state_idle", 32'(state_o), 0);

        // Abort on the 100th CLEAR cycle, then restart
        s_pix_valid = 1'b1;
        push_clear(100);
        do_start(12'd2, 12'd1);
        repeat (99) @(posedge ACLK);
        #1;
        cfg_abort = 1'b1;
        @(posedge ACLK); #1;
        cfg_abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_state", 32'(state_o), 0);
        chk("abort_ready", 32'(s_pix_ready), 0);
        repeat (20) @(posedge ACLK);
        drain("abort", 10, 1'b0);
        push_frame(2);
        do_start(12'd2, 12'd1);
        chk("restart_bin0", 32'(bin_addr), 0);
        chk("restart_clr_we", 32'(hist_clr_we), 1);
        drain("restart", 2000, 1'b0);

        // Start during ACCUM ignored
        s_pix_valid = 1'b1;
        push_frame(16);
        do_start(12'd4, 12'd4);
        wait_state("busystart", 3'd2, 400);
        cfg_width = 12'd1; cfg_height = 12'd1; cfg_start = 1'b1;
        @(posedge ACLK); #1;
        cfg_start = 1'b0;
        chk("busystart_err", 32'(cfg_err), 0);
        drain("busystart", 3000, 1'b0);
        chk("busystart_idle", 32'(state_o), 0);

        // Reset asserted during REMAP
        s_pix_valid = 1'b1;
        push_clear(256);
        push_pix(F_INC, 8);
        push_cdf();
        do_start(12'd4, 12'd2);
        wait_state("rstmid_cdf", 3'd3, 600);
        s_pix_valid = 1'b0;
        wait_state("rstmid_remap", 3'd5, 600);
        chk("rstmid_sb_empty", 32'(exp_q.size()), 0);
        #2;
        ARESETN     = 1'b0;
        s_pix_valid = 1'b1;
        #1;
        chk("rstmid_state", 32'(state_o), 0);
        chk("rstmid_busy",  32'(busy), 0);
        chk("rstmid_ready", 32'(s_pix_ready), 0);
        chk("rstmid_strobes",
            32'({pix_last, hist_clr_we, hist_inc_en, cdf_rd_en, cdf_wr_en,
                 remap_en, done, cfg_err}), 0);
        chk("rstmid_bin", 32'(bin_addr), 0);
`ifdef HISTEQ_SEQ_CTRL_PERF_EN
        chk("rstmid_perf_busy", perf_busy_cyc, 32'd0);
        chk("rstmid_perf_stall", perf_stall_cyc, 32'd0);
`endif
        exp_q.delete();
        @(posedge ACLK); #1;
        s_pix_valid = 1'b0;
        ARESETN = 1'b1;
        repeat (5) @(posedge ACLK);
        #1;
        chk("post_rst_idle", 32'(state_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
